// File: rtl/imm_extend_unit_pkg.sv
// Shared definitions for the immediate-extension unit.
//   ext_mode_e : 2-bit extension mode encodings
//   MODE_W     : width of the mode field
package imm_ext_defs;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    EXT_SIGN     = 2'b00,
    EXT_ZERO     = 2'b01,
    EXT_SIGN_SHL = 2'b10,
    EXT_UPPER    = 2'b11
  } ext_mode_e;

endpackage

// File: rtl/imm_extend_unit_core.sv
// Purely combinational immediate extender.
//   imm  : raw immediate field (IN_W bits)
//   mode : extension mode (see imm_ext_defs)
//   ext  : extended result (OUT_W bits)
// Callers are expected to keep IN_W + SHAMT <= OUT_W so the shifted
// form never loses bits.
module imm_extend_core
  import imm_ext_defs::*;
#(
  parameter int IN_W  = 21,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic [IN_W-1:0]   imm,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  ext
);

  // Width casts avoid a zero-width replication when IN_W == OUT_W.
  logic [OUT_W-1:0] sx, zx;
  assign sx = OUT_W'(signed'(imm));
  assign zx = OUT_W'(imm);

  always_comb begin
    ext = sx;
    case (ext_mode_e'(mode))
      EXT_SIGN:     ext = sx;
      EXT_ZERO:     ext = zx;
      EXT_SIGN_SHL: ext = sx << SHAMT;
      EXT_UPPER:    ext = zx << (OUT_W - IN_W);
      default:      ext = sx;
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Registered immediate-extension stage with valid/ready handshake and a
// one-entry skid buffer.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake (in_ready = !skid_valid)
//   in_imm, in_mode      : raw immediate and extension mode
//   out_valid/out_ready  : downstream handshake
//   out_data             : extended result
module imm_extend_unit
  import imm_ext_defs::*;
#(
  parameter int IN_W  = 21,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
);

  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic [OUT_W-1:0] ext;
  logic             accept;
  logic             out_free;

  imm_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT(SHAMT)) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .ext  (ext)
  );

  // in_ready comes straight from a flop: no comb path from out_ready.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_free) begin
      // Skid holds the older item, so it drains first; in_ready is low
      // whenever skid is full, so no accept can collide with it.
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_data  <= ext;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new item in the skid.
      skid_data  <= ext;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
module tb_imm_extend_unit;
  import imm_ext_defs::*;

  localparam int IN_W = 21, OUT_W = 32, SHAMT = 2;
  localparam int IN_W_B = 12, SHAMT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [IN_W-1:0]   in_imm = '0;
  logic [MODE_W-1:0] in_mode = '0;
  logic [OUT_W-1:0]  out_data;

  logic              b_valid = 1'b0, b_ready, b_ovalid;
  logic [IN_W_B-1:0] b_imm = '0;
  logic [MODE_W-1:0] b_mode = '0;
  logic [OUT_W-1:0]  b_data;

  imm_extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT(SHAMT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  imm_extend_unit #(.IN_W(IN_W_B), .OUT_W(OUT_W), .SHAMT(SHAMT_B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_imm(b_imm), .in_mode(b_mode), .out_valid(b_ovalid),
    .out_ready(1'b1), .out_data(b_data)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: treat the immediate as an integer and apply the arithmetic
  // meaning of each mode, then reduce modulo 2^OUT_W.
  function automatic logic [OUT_W-1:0] model(input int iw, input int sh,
                                             input longint imm, input logic [1:0] mode);
    longint v, m;
    m = (longint'(1) << OUT_W);
    v = imm;
    if (imm >= (longint'(1) << (iw - 1))) v = imm - (longint'(1) << iw);
    case (mode)
      2'b00: v = v;
      2'b01: v = imm;
      2'b10: v = v * (longint'(1) << sh);
      default: v = imm * (longint'(1) << (OUT_W - iw));
    endcase
    v = ((v % m) + m) % m;
    return v[OUT_W-1:0];
  endfunction

  // Scoreboard on the main DUT: what goes in must come out, once, in order;
  // stalled outputs must hold.
  logic [OUT_W-1:0] exp_q[$];
  logic             stall_d = 1'b0;
  logic [OUT_W-1:0] stall_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_d = 1'b0;
    end else begin
      if (stall_d) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, stall_data);
      end
      if (out_valid && out_ready) begin
        total++;
        assert (exp_q.size() > 0) else begin
          bad++;
          $error("FAIL spurious_out observed=%h expected=none", out_data);
        end
        if (exp_q.size() > 0) chk("sb_order", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(IN_W, SHAMT, longint'(in_imm), in_mode));
      stall_d    = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [IN_W-1:0] imm, input logic [1:0] mode);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
  endtask

  task automatic one(input string tag, input logic [IN_W-1:0] imm,
                     input logic [1:0] mode, input logic [OUT_W-1:0] exp);
    drive(imm, mode);
    step();
    in_valid = 1'b0;
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk(tag, out_data, exp);
  endtask

  logic [OUT_W-1:0] ea, eb, ec, e;
  logic [IN_W-1:0]  r;
  logic [1:0]       rm;

  initial begin
    repeat (3) step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    // Directed mode vectors.
    one("sign_neg", 21'h10B684, EXT_SIGN, 32'hFFF0B684);
    one("sign_pos", 21'h0E921C, EXT_SIGN, 32'h000E921C);
    one("zero", 21'h10B684, EXT_ZERO, 32'h0010B684);
    one("sign_shl", 21'h10B684, EXT_SIGN_SHL, 32'hFFC2DA10);
    one("upper", 21'h10B684, EXT_UPPER, 32'h85B42000);
    one("sign_max", 21'h1FFFFF, EXT_SIGN, 32'hFFFFFFFF);
    one("shl_min", 21'h100000, EXT_SIGN_SHL, 32'hFFC00000);
    step();
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Backpressure: A held, B in skid, C waits.
    ea = model(IN_W, SHAMT, 64'h12345, 2'b00);
    eb = model(IN_W, SHAMT, 64'h1ABCD, 2'b11);
    ec = model(IN_W, SHAMT, 64'h0F0F0, 2'b10);
    out_ready = 1'b0;
    drive(21'h12345, EXT_SIGN);   step();
    chk("bp_a_out", out_data, ea);
    drive(21'h1ABCD, EXT_UPPER);  step();
    chk("bp_skid_ready", 32'(in_ready), 32'd0);
    chk("bp_a_hold", out_data, ea);
    drive(21'h0F0F0, EXT_SIGN_SHL);
    in_mode = EXT_ZERO;           step();  // mode change while stalled
    in_mode = EXT_SIGN_SHL;
    chk("bp_a_hold2", out_data, ea);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;             step();
    chk("bp_b_out", out_data, eb);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_c_out", out_data, ec);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Full-rate streaming.
    for (int i = 0; i < 8; i++) begin
      r  = IN_W'($urandom);
      rm = 2'($urandom);
      drive(r, rm);
      e = model(IN_W, SHAMT, longint'(r), rm);
      chk("stream_ready", 32'(in_ready), 32'd1);
      step();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data", out_data, e);
    end
    in_valid = 1'b0;
    step();

    // Reset with output stage and skid both full.
    out_ready = 1'b0;
    drive(21'h00AAA, EXT_ZERO);  step();
    drive(21'h15555, EXT_SIGN);  step();
    chk("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;                  step();
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_data", out_data, 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_no_stale", 32'(out_valid), 32'd0);
    end

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_imm    = IN_W'($urandom);
      in_mode   = 2'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_idle", 32'(out_valid), 32'd0);

    // Narrow-field instance.
    b_valid = 1'b1; b_imm = 12'h800; b_mode = EXT_SIGN_SHL; step();
    chk("b_shl", b_data, 32'hFFFFF000);
    b_imm = 12'hABC; b_mode = EXT_UPPER; step();
    chk("b_upper", b_data, 32'hABC00000);
    b_imm = 12'h7FF; b_mode = EXT_SIGN; step();
    chk("b_sign", b_data, model(IN_W_B, SHAMT_B, 64'h7FF, 2'b00));
    b_valid = 1'b0;
    step();
    chk("b_idle", 32'(b_ovalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_extend_unit.md
Name: imm_extend_unit

Overview:
Parametrised immediate-extension stage for the datapath's decode path, successor to the fixed 21-to-32 sign extender. It supports four extension modes: sign, zero, sign-shifted (branch/jump offsets) and upper-immediate. Results are registered behind a valid/ready handshake with a one-entry skid buffer, so the unit can sit between pipelined decode and execute without a combinational ready path.

Parameters:
IN_W, 21, width of raw immediate field; legal range 1..OUT_W-SHAMT.
OUT_W, 32, width of extended result.
SHAMT, 2, left-shift amount applied in SIGN_SHL mode; legal range 0..OUT_W-IN_W.

Ports:
clk  input  1  single clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  upstream has an immediate to extend.
in_ready  output  1  unit can accept; equals NOT skid_valid (registered source, no comb path from out_ready).
in_imm  input  IN_W  raw immediate field.
in_mode  input  2  extension mode: 00 SIGN, 01 ZERO, 10 SIGN_SHL, 11 UPPER.
out_valid  output  1  out_data holds a valid result.
out_ready  input  1  downstream accepts out_data this cycle.
out_data  output  OUT_W  extended result.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset: out_valid=0, out_data=0, skid_valid=0, skid_data=0, so in_ready=1 from the first cycle after rst deasserts. While rst=1, in_valid is ignored and nothing is accepted.
- Extension function ext(imm, mode), computed combinationally and registered:
  SIGN: {(OUT_W-IN_W){imm[IN_W-1]}, imm}.
  ZERO: {(OUT_W-IN_W){1'b0}, imm}.
  SIGN_SHL: SIGN result << SHAMT, truncated to OUT_W (no loss given the parameter constraints).
  UPPER: {imm, (OUT_W-IN_W){1'b0}}.
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Latency: an accepted item appears on out_data the next cycle when the output stage is free (empty or draining) and the skid is empty. Steady-state throughput is 1 item/cycle when out_ready=1.
- Stage update rules, evaluated per cycle:
  If accept and (NOT out_valid or drain) and NOT skid_valid: output stage <= ext(in).
  If accept and out_valid and NOT out_ready: skid <= ext(in), skid_valid<=1.
  If drain and skid_valid: output stage <= skid, skid_valid<=0. No accept is possible here because in_ready=0.
  If drain, no skid and no accept: out_valid<=0. out_data holds its last value.
- out_data and out_valid are stable while out_valid=1 and out_ready=0. No item is ever dropped or duplicated, and order is preserved.
- Simultaneous accept+drain with empty skid: the new item replaces the output stage and out_valid stays 1.
- Reset mid-operation: any buffered items are discarded and all state returns to reset values on the next edge.
- in_mode is sampled only on accept. Changing in_mode while stalled has no effect on buffered data.

Decomposition:
- Shared header/package imm_ext_defs: mode encodings EXT_SIGN=2'b00, EXT_ZERO=2'b01, EXT_SIGN_SHL=2'b10, EXT_UPPER=2'b11, and the 2-bit mode width constant.
- Sub-module imm_extend_core: purely combinational ext(imm, mode) with parameters IN_W/OUT_W/SHAMT. imm_extend_unit holds only the output stage, the skid register and the handshake logic.

Test Plan:
- Defaults, SIGN, in_imm=21'h10B684, out_ready=1 -> out_data=32'hFFF0B684 one cycle after accept. in_imm=21'h0E921C -> 32'h000E921C.
- ZERO 21'h10B684 -> 32'h0010B684. SIGN_SHL 21'h10B684 -> 32'hFFC2DA10. UPPER 21'h10B684 -> 32'h85B42000.
- Backpressure: stream A,B,C with out_ready=0 -> A held on out_data, B in skid, in_ready=0 from the cycle after B is accepted. Release out_ready -> A,B,C emerge in order, none lost or duplicated.
- Full-rate streaming of 8 back-to-back items with out_ready=1 -> one result per cycle, in_ready constantly 1.
- rst asserted for one cycle with output and skid both full -> next cycle out_valid=0, out_data=0, in_ready=1, and no stale item is emitted afterwards.
- Parameter sweep IN_W=12, OUT_W=32, SHAMT=1: SIGN_SHL 12'h800 -> 32'hFFFFF000. UPPER 12'hABC -> 32'hABC00000.
